// File: rtl/pdh_gpio_cmd.sv
// Command decoder and config register bank between the PS GPIO word and pdh_core.
// Toggle-strobe handshake: synchronise, settle, execute, acknowledge.
module pdh_gpio_cmd #(
    parameter int NUM_REGS   = 8,
    parameter int REG_WIDTH  = 24,
    parameter int GPIO_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [GPIO_WIDTH-1:0]         axi_from_ps_i,
    output logic [GPIO_WIDTH-1:0]         axi_to_ps_o,
    input  logic [REG_WIDTH-1:0]          status_i,
    output logic [NUM_REGS*REG_WIDTH-1:0] cfg_o,
    output logic [NUM_REGS-1:0]           cfg_wr_o
);

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        SETTLE,
        EXEC,
        ACK
    } state_t;

    localparam logic [3:0] ADDR_STATUS = 4'hF;

    state_t                          state_q, state_d;
    logic [GPIO_WIDTH-1:0]           s1_q, s2_q;
    logic [GPIO_WIDTH-1:0]           cap_q, cap_d;
    logic [1:0]                      init_cnt_q, init_cnt_d;
    logic                            last_strobe_q, last_strobe_d;
    logic                            err_q, err_d;
    logic [REG_WIDTH-1:0]            rdata_q, rdata_d;
    logic [GPIO_WIDTH-1:0]           axi_q, axi_d;
    logic [NUM_REGS*REG_WIDTH-1:0]   cfg_q, cfg_d;
    logic [NUM_REGS-1:0]             cfg_wr_q, cfg_wr_d;

    logic                            cap_rw;
    logic [3:0]                      cap_addr;

    assign cap_rw   = cap_q[30];
    assign cap_addr = cap_q[27:24];

    // NOTE: every signal written here gets a default first, so no path can leave
    // it unassigned and infer a latch; blocking '=' is correct in combinational code.
    always_comb begin
        state_d       = state_q;
        cap_d         = cap_q;
        init_cnt_d    = init_cnt_q;
        last_strobe_d = last_strobe_q;
        err_d         = err_q;
        rdata_d       = rdata_q;
        axi_d         = axi_q;
        cfg_d         = cfg_q;
        cfg_wr_d      = '0;

        case (state_q)
            INIT: begin
                // Let the synchroniser fill so a strobe held through reset is not a command.
                if (init_cnt_q == 2'd2) begin
                    last_strobe_d = s2_q[31];
                    state_d       = IDLE;
                end else begin
                    init_cnt_d = init_cnt_q + 2'd1;
                end
            end
            IDLE: begin
                if (s2_q[31] != last_strobe_q) begin
                    cap_d   = s2_q;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (s2_q == cap_q) begin
                    state_d = EXEC;
                end else begin
                    cap_d = s2_q;
                end
            end
            EXEC: begin
                err_d   = 1'b1;
                rdata_d = '0;
                if (!cap_rw && cap_addr == ADDR_STATUS) begin
                    err_d   = 1'b0;
                    rdata_d = status_i;
                end
                for (int k = 0; k < NUM_REGS; k++) begin
                    if (cap_addr == 4'(k)) begin
                        err_d = 1'b0;
                        if (cap_rw) begin
                            cfg_d[k*REG_WIDTH +: REG_WIDTH] = cap_q[REG_WIDTH-1:0];
                            cfg_wr_d[k]                     = 1'b1;
                            rdata_d                         = cap_q[REG_WIDTH-1:0];
                        end else begin
                            rdata_d = cfg_q[k*REG_WIDTH +: REG_WIDTH];
                        end
                    end
                end
                state_d = ACK;
            end
            ACK: begin
                axi_d         = {cap_q[31], err_q, 2'b00, cap_addr, rdata_q};
                last_strobe_d = cap_q[31];
                state_d       = IDLE;
            end
            default: state_d = INIT;
        endcase
    end

    // NOTE: the register bank is a plain flop vector, so it is cleared by reset
    // like any other state; sequential blocks use non-blocking '<=' only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= INIT;
            s1_q          <= '0;
            s2_q          <= '0;
            cap_q         <= '0;
            init_cnt_q    <= '0;
            last_strobe_q <= 1'b0;
            err_q         <= 1'b0;
            rdata_q       <= '0;
            axi_q         <= '0;
            cfg_q         <= '0;
            cfg_wr_q      <= '0;
        end else begin
            state_q       <= state_d;
            s1_q          <= axi_from_ps_i;
            s2_q          <= s1_q;
            cap_q         <= cap_d;
            init_cnt_q    <= init_cnt_d;
            last_strobe_q <= last_strobe_d;
            err_q         <= err_d;
            rdata_q       <= rdata_d;
            axi_q         <= axi_d;
            cfg_q         <= cfg_d;
            cfg_wr_q      <= cfg_wr_d;
        end
    end

    assign axi_to_ps_o = axi_q;
    assign cfg_o       = cfg_q;
    assign cfg_wr_o    = cfg_wr_q;

endmodule

// File: tb/tb_pdh_gpio_cmd.sv
// Self-checking bench for pdh_gpio_cmd: directed, randomized, glitch and reset
// scenarios compared against a register-bank reference model.
module tb_pdh_gpio_cmd;

    localparam int NUM_REGS = 8;
    localparam int RW       = 24;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [31:0]              axi_from_ps_i;
    logic [31:0]              axi_to_ps_o;
    logic [RW-1:0]            status_i;
    logic [NUM_REGS*RW-1:0]   cfg_o;
    logic [NUM_REGS-1:0]      cfg_wr_o;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [RW-1:0] m_regs [NUM_REGS];
    logic [31:0]   m_resp;
    logic          strobe;

    pdh_gpio_cmd #(.NUM_REGS(NUM_REGS), .REG_WIDTH(RW), .GPIO_WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .axi_from_ps_i(axi_from_ps_i),
        .axi_to_ps_o  (axi_to_ps_o),
        .status_i     (status_i),
        .cfg_o        (cfg_o),
        .cfg_wr_o     (cfg_wr_o)
    );

    always #5 clk = ~clk;

    function automatic logic [NUM_REGS*RW-1:0] model_cfg();
        logic [NUM_REGS*RW-1:0] v;
        v = '0;
        for (int k = 0; k < NUM_REGS; k++) v[k*RW +: RW] = m_regs[k];
        return v;
    endfunction

    function automatic void model_clear();
        for (int k = 0; k < NUM_REGS; k++) m_regs[k] = '0;
        m_resp = '0;
    endfunction

    // Issue one toggle command at a negedge and follow it for exactly 6 cycles,
    // checking pulse timing, response timing and the resulting bank.
    task automatic send_cmd(input bit rw, input logic [3:0] addr,
                            input logic [RW-1:0] payload, input logic [RW-1:0] status,
                            input string name);
        logic [31:0]         exp_resp, prev_resp;
        logic [NUM_REGS-1:0] exp_mask;
        logic [RW-1:0]       data;
        logic                err;
        logic [1:0]          resv;

        strobe   = ~strobe;
        status_i = status;
        err      = 1'b1;
        data     = '0;
        exp_mask = '0;
        if (!rw && addr == 4'hF) begin
            err  = 1'b0;
            data = status;
        end else if (int'(addr) < NUM_REGS) begin
            err = 1'b0;
            if (rw) begin
                m_regs[addr] = payload;
                exp_mask[addr] = 1'b1;
                data = payload;
            end else begin
                data = m_regs[addr];
            end
        end
        exp_resp  = {strobe, err, 2'b00, addr, data};
        prev_resp = m_resp;
        resv      = 2'($urandom_range(0, 3));
        axi_from_ps_i = {strobe, rw, resv, addr, payload};

        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            n_checks++;
            if (cfg_wr_o !== ((k == 5) ? exp_mask : '0)) begin
                n_errors++;
                $display("FAIL %s cfg_wr cycle %0d: got %h expected %h", name, k, cfg_wr_o,
                         (k == 5) ? exp_mask : '0);
            end
            n_checks++;
            if (axi_to_ps_o !== ((k == 6) ? exp_resp : prev_resp)) begin
                n_errors++;
                $display("FAIL %s resp cycle %0d: got %h expected %h", name, k, axi_to_ps_o,
                         (k == 6) ? exp_resp : prev_resp);
            end
        end
        m_resp = exp_resp;
        n_checks++;
        if (cfg_o !== model_cfg()) begin
            n_errors++;
            $display("FAIL %s cfg: got %h expected %h", name, cfg_o, model_cfg());
        end
    endtask

    task automatic quiet_window(input int cycles, input string name);
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            n_checks++;
            if (cfg_wr_o !== '0 || axi_to_ps_o !== m_resp || cfg_o !== model_cfg()) begin
                n_errors++;
                $display("FAIL %s idle cycle %0d: wr=%h resp=%h (exp %h) cfg=%h (exp %h)",
                         name, k, cfg_wr_o, axi_to_ps_o, m_resp, cfg_o, model_cfg());
            end
        end
    endtask

    task automatic apply_reset(input logic [31:0] word);
        axi_from_ps_i = word;
        strobe        = word[31];
        rst           = 1'b1;
        repeat (3) @(negedge clk);
        model_clear();
        n_checks++;
        if (axi_to_ps_o !== 32'h0 || cfg_o !== '0 || cfg_wr_o !== '0) begin
            n_errors++;
            $display("FAIL reset_state: resp=%h cfg=%h wr=%h expected all 0",
                     axi_to_ps_o, cfg_o, cfg_wr_o);
        end
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset(32'h8000_0000);
        quiet_window(10, "reset_strobe_high");
        apply_reset(32'h0000_0000);
        quiet_window(5, "reset_strobe_low");
    endtask

    task automatic test_directed();
        send_cmd(1'b1, 4'd3, 24'hABCDEF, 24'h000000, "write_addr3");
        n_checks++;
        if (axi_to_ps_o !== 32'h83ABCDEF) begin
            n_errors++;
            $display("FAIL write_addr3_literal: got %h expected 83abcdef", axi_to_ps_o);
        end
        send_cmd(1'b0, 4'd3, 24'h000000, 24'h000000, "read_addr3");
        n_checks++;
        if (axi_to_ps_o !== 32'h03ABCDEF) begin
            n_errors++;
            $display("FAIL read_addr3_literal: got %h expected 03abcdef", axi_to_ps_o);
        end
        send_cmd(1'b0, 4'hF, 24'h000000, 24'h123456, "read_status");
        n_checks++;
        if (axi_to_ps_o !== 32'h8F123456) begin
            n_errors++;
            $display("FAIL read_status_literal: got %h expected 8f123456", axi_to_ps_o);
        end
    endtask

    task automatic test_errors();
        send_cmd(1'b1, 4'hF, 24'h5A5A5A, 24'h777777, "write_addr15");
        send_cmd(1'b1, 4'd9, 24'h0F0F0F, 24'h000000, "write_addr9");
        send_cmd(1'b0, 4'd8, 24'h000000, 24'h000000, "read_addr8");
        send_cmd(1'b1, 4'd14, 24'hFFFFFF, 24'h000000, "write_addr14");
    endtask

    // Commands are issued back to back at the minimum 6-cycle period.
    task automatic test_back_to_back_random();
        for (int i = 0; i < 40; i++) begin
            send_cmd(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                     24'($urandom), 24'($urandom), "random");
        end
        for (int k = 0; k < NUM_REGS; k++) begin
            send_cmd(1'b0, 4'(k), 24'($urandom), 24'($urandom), "readback_all");
        end
    endtask

    task automatic test_glitch();
        int pulses;
        logic [31:0] exp_resp;
        strobe = ~strobe;
        axi_from_ps_i = {strobe, 1'b1, 2'b00, 4'd5, 24'h000011};
        @(negedge clk);
        axi_from_ps_i = {strobe, 1'b1, 2'b00, 4'd5, 24'h000022};
        m_regs[5] = 24'h000022;
        exp_resp  = {strobe, 1'b0, 2'b00, 4'd5, 24'h000022};
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (cfg_wr_o !== '0) begin
                pulses++;
                n_checks++;
                if (cfg_wr_o !== 8'h20) begin
                    n_errors++;
                    $display("FAIL glitch_mask: got %h expected 20", cfg_wr_o);
                end
            end
        end
        m_resp = exp_resp;
        n_checks++;
        if (pulses != 1) begin
            n_errors++;
            $display("FAIL glitch_pulses: got %0d expected 1", pulses);
        end
        n_checks++;
        if (axi_to_ps_o !== exp_resp || cfg_o !== model_cfg()) begin
            n_errors++;
            $display("FAIL glitch_result: resp=%h (exp %h) cfg=%h (exp %h)",
                     axi_to_ps_o, exp_resp, cfg_o, model_cfg());
        end
    endtask

    task automatic test_reset_exec();
        strobe = ~strobe;
        axi_from_ps_i = {strobe, 1'b1, 2'b00, 4'd2, 24'hC0FFEE};
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        model_clear();
        n_checks++;
        if (cfg_wr_o !== '0 || axi_to_ps_o !== 32'h0 || cfg_o !== '0) begin
            n_errors++;
            $display("FAIL reset_exec: wr=%h resp=%h cfg=%h expected all 0",
                     cfg_wr_o, axi_to_ps_o, cfg_o);
        end
        @(negedge clk);
        rst = 1'b0;
        quiet_window(10, "reset_exec_after");
        send_cmd(1'b1, 4'd7, 24'h13579B, 24'h000000, "recover_write");
        send_cmd(1'b0, 4'd2, 24'h000000, 24'h000000, "recover_read2");
    endtask

    initial begin
        rst           = 1'b1;
        axi_from_ps_i = '0;
        status_i      = '0;
        strobe        = 1'b0;
        model_clear();
        @(negedge clk);
        test_reset();
        test_directed();
        test_errors();
        test_back_to_back_random();
        test_glitch();
        test_reset_exec();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
